// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and IR field positions for the multi-cycle CPU controller
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_ADDI = 3'd1,
    OP_SUB  = 3'd2,
    OP_NAND = 3'd3,
    OP_BNE  = 3'd4,
    OP_LW   = 3'd5,
    OP_SW   = 3'd6,
    OP_J    = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    FETCH_SETUP  = 3'd0,
    FETCH_ACCESS = 3'd1,
    DECODE       = 3'd2,
    EXEC         = 3'd3,
    MEM_SETUP    = 3'd4,
    MEM_ACCESS   = 3'd5,
    WB           = 3'd6,
    FAULT        = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_NAND = 3'b010
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_INC = 2'd0,
    PC_IMM = 2'd1,
    PC_ALU = 2'd2
  } pc_sel_t;

  localparam int OP_MSB     = 15;
  localparam int OP_LSB     = 13;
  localparam int RD_MSB     = 12;
  localparam int RD_LSB     = 10;
  localparam int RS1_MSB    = 9;
  localparam int RS1_LSB    = 7;
  localparam int RS2_MSB    = 6;
  localparam int RS2_LSB    = 4;
  localparam int IMM7_MSB   = 6;
  localparam int IMM_LO_MSB = 3;

  // Format 3 splits its immediate around rs1/rs2 and has no rd field
  function automatic logic is_fmt3(input opcode_t op);
    return (op == OP_BNE) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/cpu_imm_decode.sv
// rtl/cpu_imm_decode.sv - format-dependent 7-bit immediate extraction and sign extension
module cpu_imm_decode
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  opcode_t            opcode,
  input  logic [15:0]        ir,
  output logic [DATA_W-1:0]  imm_ext
);

  logic [6:0] imm7;

  always_comb begin
    if (is_fmt3(opcode)) begin
      imm7 = {ir[RD_MSB:RD_LSB], ir[IMM_LO_MSB:0]};
    end else begin
      imm7 = ir[IMM7_MSB:0];
    end
    imm_ext = {{(DATA_W-7){imm7[6]}}, imm7};
  end

endmodule

// File: rtl/cpu_control_mc.sv
// rtl/cpu_control_mc.sv - multi-cycle control FSM with shared APB master handshake
// Optional ACCESS-phase watchdog: define CPU_CTRL_TIMEOUT_EN.
module cpu_control_mc
  import cpu_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int RADDR_W     = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        ir,
  input  logic [DATA_W-1:0]  reg_1,
  input  logic [DATA_W-1:0]  reg_2,
  input  logic               pready,
  input  logic               pslverr,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic               addr_sel,
  output logic               ir_load,
  output logic               pc_load,
  output logic [1:0]         pc_sel,
  output logic [RADDR_W-1:0] rf_wr_sel,
  output logic [RADDR_W-1:0] reg_1_sel,
  output logic [RADDR_W-1:0] reg_2_sel,
  output logic               r1_sel,
  output logic               r2_sel,
  output logic [2:0]         alu_sel,
  output logic               wb_sel,
  output logic               rf_we,
  output logic [DATA_W-1:0]  imm_ext,
  output logic               fault,
  output logic [2:0]         state
);

  if (RADDR_W != 3) begin : g_bad_raddr
    $error("cpu_control_mc: RADDR_W must be 3 to match the IR register fields");
  end

  state_t              state_q, state_d;
  opcode_t             op_q;
  logic [RADDR_W-1:0]  rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0]   imm_q, imm_dec;
  opcode_t             ir_op;
  logic [RADDR_W-1:0]  dec_rd;
  logic                timed_out;
  logic                op_uses_imm;
  alu_op_t             op_alu;
  alu_op_t             alu_v;
  pc_sel_t             pc_v;

  assign ir_op  = opcode_t'(ir[OP_MSB:OP_LSB]);
  // Loads write the rs2 slot since format 3 carries no rd
  assign dec_rd = is_fmt3(ir_op) ? ir[RS2_MSB:RS2_LSB] : ir[RD_MSB:RD_LSB];

  cpu_imm_decode #(.DATA_W(DATA_W)) u_imm_decode (
    .opcode  (ir_op),
    .ir      (ir),
    .imm_ext (imm_dec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH_SETUP;
      op_q    <= OP_ADD;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        op_q  <= ir_op;
        rd_q  <= dec_rd;
        rs1_q <= ir[RS1_MSB:RS1_LSB];
        rs2_q <= ir[RS2_MSB:RS2_LSB];
        imm_q <= imm_dec;
      end
    end
  end

`ifdef CPU_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if ((state_q != FETCH_ACCESS) && (state_q != MEM_ACCESS)) begin
      wait_cnt <= '0;
    end else if (!pready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // The wait that would bring the count to TIMEOUT_CYC aborts; a ready on that cycle completes instead
  assign timed_out = !pready && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
  assign timed_out      = 1'b0;
`endif

  assign op_uses_imm = (op_q == OP_ADDI) || (op_q == OP_LW) || (op_q == OP_SW) || (op_q == OP_J);
  assign op_alu      = (op_q == OP_SUB) ? ALU_SUB : (op_q == OP_NAND) ? ALU_NAND : ALU_ADD;

  always_comb begin
    state_d  = state_q;
    psel     = 1'b0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    addr_sel = 1'b0;
    ir_load  = 1'b0;
    pc_load  = 1'b0;
    pc_v     = PC_INC;
    r1_sel   = 1'b0;
    r2_sel   = 1'b0;
    alu_v    = ALU_ADD;
    wb_sel   = 1'b0;
    rf_we    = 1'b0;
    // Reset gates the handshake combinationally so a pending access is dropped at once
    if (reset) begin
      case (state_q)
        FETCH_SETUP: begin
          psel    = 1'b1;
          state_d = FETCH_ACCESS;
        end
        FETCH_ACCESS: begin
          psel    = 1'b1;
          penable = 1'b1;
          if (pready) begin
            if (pslverr) begin
              state_d = FAULT;
            end else begin
              ir_load = 1'b1;
              state_d = DECODE;
            end
          end else if (timed_out) begin
            state_d = FAULT;
          end
        end
        DECODE: state_d = EXEC;
        EXEC: begin
          r2_sel = op_uses_imm;
          alu_v  = op_alu;
          case (op_q)
            OP_BNE: begin
              r2_sel  = 1'b0;
              pc_v    = (reg_1 != reg_2) ? PC_IMM : PC_INC;
              pc_load = 1'b1;
              state_d = FETCH_SETUP;
            end
            OP_J: begin
              pc_v    = PC_ALU;
              pc_load = 1'b1;
              state_d = FETCH_SETUP;
            end
            OP_LW, OP_SW: state_d = MEM_SETUP;
            default:      state_d = WB;
          endcase
        end
        MEM_SETUP: begin
          psel     = 1'b1;
          addr_sel = 1'b1;
          pwrite   = (op_q == OP_SW);
          r2_sel   = 1'b1;
          state_d  = MEM_ACCESS;
        end
        MEM_ACCESS: begin
          psel     = 1'b1;
          penable  = 1'b1;
          addr_sel = 1'b1;
          pwrite   = (op_q == OP_SW);
          r2_sel   = 1'b1;
          if (pready) begin
            if (pslverr) begin
              state_d = FAULT;
            end else if (op_q == OP_SW) begin
              pc_load = 1'b1;
              state_d = FETCH_SETUP;
            end else begin
              state_d = WB;
            end
          end else if (timed_out) begin
            state_d = FAULT;
          end
        end
        WB: begin
          rf_we   = 1'b1;
          wb_sel  = (op_q == OP_LW);
          r2_sel  = op_uses_imm;
          alu_v   = op_alu;
          pc_load = 1'b1;
          state_d = FETCH_SETUP;
        end
        FAULT:   state_d = FAULT;
        default: state_d = FAULT;
      endcase
    end
  end

  assign pc_sel    = pc_v;
  assign alu_sel   = alu_v;
  assign reg_1_sel = (state_q == DECODE) ? ir[RS1_MSB:RS1_LSB] : rs1_q;
  assign reg_2_sel = (state_q == DECODE) ? ir[RS2_MSB:RS2_LSB] : rs2_q;
  assign rf_wr_sel = (state_q == DECODE) ? dec_rd : rd_q;
  assign imm_ext   = imm_q;
  assign fault     = (state_q == FAULT);
  assign state     = state_q;

endmodule

// File: tb/tb_cpu_control_mc.sv
// tb/tb_cpu_control_mc.sv - vector table, hand sequences and random instructions against a latency/decode model
module tb_cpu_control_mc;
  import cpu_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   ir = 16'h0;
  logic [DW-1:0] reg_1 = '0, reg_2 = '0;
  logic          pready = 1'b0, pslverr = 1'b0;
  logic          psel, penable, pwrite, addr_sel, ir_load, pc_load;
  logic [1:0]    pc_sel;
  logic [2:0]    rf_wr_sel, reg_1_sel, reg_2_sel, alu_sel, state;
  logic          r1_sel, r2_sel, wb_sel, rf_we, fault;
  logic [DW-1:0] imm_ext;

  cpu_control_mc #(.DATA_W(DW), .RADDR_W(3), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .reset(reset), .ir(ir), .reg_1(reg_1), .reg_2(reg_2),
    .pready(pready), .pslverr(pslverr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .addr_sel(addr_sel), .ir_load(ir_load), .pc_load(pc_load),
    .pc_sel(pc_sel), .rf_wr_sel(rf_wr_sel), .reg_1_sel(reg_1_sel), .reg_2_sel(reg_2_sel),
    .r1_sel(r1_sel), .r2_sel(r2_sel), .alu_sel(alu_sel), .wb_sel(wb_sel),
    .rf_we(rf_we), .imm_ext(imm_ext), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int obs_lat, obs_pcl, obs_pcsel, obs_rfwe, obs_wbsel, obs_wrsel, obs_r2sel, obs_alusel;
  int obs_r1s, obs_r2s, obs_viol, obs_pwrite, obs_fault, obs_end, obs_r1sel;
  logic [DW-1:0] obs_imm;

  typedef struct {
    logic [15:0]   ir;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            fw;
    int            mw;
    int            lat;
    int            pcsel;
    int            rfwe;
    bit            has_imm;
    logic [DW-1:0] imm;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input int op, input int fw, input int mw);
    if (op == 4 || op == 7) return 4 + fw;
    if (op == 6) return 6 + fw + mw;
    if (op == 5) return 7 + fw + mw;
    return 5 + fw;
  endfunction

  function automatic logic [DW-1:0] exp_imm(input logic [15:0] instr);
    int op, v;
    op = int'(instr[15:13]);
    if (op >= 4 && op <= 6) v = int'(instr[12:10]) * 16 + int'(instr[3:0]);
    else v = int'(instr[6:0]);
    if (v >= 64) v = v - 128;
    return DW'(v);
  endfunction

  // Entry and exit at posedge+1 with the DUT in FETCH_SETUP
  task automatic run_instr(input logic [15:0] instr, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input int fw, input int mw, input bit err);
    int acc;
    bit done, load_seen;
    logic [2:0] pst;
    logic pps, ppw, pas;
    acc = 0; done = 0; load_seen = 0; pst = 3'd0; pps = 0; ppw = 0; pas = 0;
    obs_lat = -1; obs_pcl = 0; obs_pcsel = -1; obs_rfwe = 0; obs_wbsel = -1; obs_wrsel = -1;
    obs_r2sel = -1; obs_alusel = -1; obs_r1s = -1; obs_r2s = -1; obs_viol = 0; obs_pwrite = 0;
    obs_fault = 0; obs_r1sel = 0; obs_imm = '0;
    reg_1 = a; reg_2 = b; ir = ~instr;
    for (int c = 1; c <= 60 && !done; c++) begin
      if (load_seen) ir = instr;
      pready = 1'b0; pslverr = 1'b0;
      if (state == 3'd1 && acc == fw) pready = 1'b1;
      if (state == 3'd5 && acc == mw) begin pready = 1'b1; pslverr = err; end
      #1;
      if (penable && !psel) obs_viol++;
      if ((state == 3'd1 && (pst == 3'd0 || pst == 3'd1)) || (state == 3'd5 && (pst == 3'd4 || pst == 3'd5)))
        if (psel !== pps || pwrite !== ppw || addr_sel !== pas) obs_viol++;
      if (pwrite) obs_pwrite = 1;
      if (r1_sel) obs_r1sel = 1;
      if (state == 3'd3) begin
        obs_imm = imm_ext; obs_r2sel = int'(r2_sel); obs_alusel = int'(alu_sel);
        obs_r1s = int'(reg_1_sel); obs_r2s = int'(reg_2_sel);
      end
      if (rf_we) begin obs_rfwe++; obs_wrsel = int'(rf_wr_sel); obs_wbsel = int'(wb_sel); end
      pst = state; pps = psel; ppw = pwrite; pas = addr_sel;
      if (state == 3'd1 || state == 3'd5) acc = pready ? 0 : acc + 1; else acc = 0;
      if (ir_load) load_seen = 1;
      if (pc_load) begin obs_pcl++; obs_pcsel = int'(pc_sel); obs_lat = c; done = 1; end
      if (state == 3'd7) begin obs_fault = 1; done = 1; end
      @(posedge clk); #1;
    end
    obs_end = int'(state);
    pready = 1'b0; pslverr = 1'b0;
  endtask

  task automatic check_instr(input string tag, input logic [15:0] instr, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input int fw, input int mw);
    int op;
    bit writes;
    op = int'(instr[15:13]);
    writes = (op <= 3) || (op == 5);
    run_instr(instr, a, b, fw, mw, 1'b0);
    chk($sformatf("%s latency", tag), obs_lat, exp_latency(op, fw, mw));
    chk($sformatf("%s pc_sel", tag), obs_pcsel, (op == 4) ? int'(a != b) : (op == 7) ? 2 : 0);
    chk($sformatf("%s rf_we count", tag), obs_rfwe, writes ? 1 : 0);
    if (writes) begin
      chk($sformatf("%s rf_wr_sel", tag), obs_wrsel, (op == 5) ? int'(instr[6:4]) : int'(instr[12:10]));
      chk($sformatf("%s wb_sel", tag), obs_wbsel, (op == 5) ? 1 : 0);
    end
    if (op == 1 || op >= 4) chk($sformatf("%s imm_ext", tag), obs_imm, exp_imm(instr));
    if (op != 4) begin
      chk($sformatf("%s r2_sel", tag), obs_r2sel, (op == 1 || op >= 5) ? 1 : 0);
      chk($sformatf("%s alu_sel", tag), obs_alusel, (op == 2) ? 1 : (op == 3) ? 2 : 0);
    end else begin
      chk($sformatf("%s bne r2_sel", tag), obs_r2sel, 0);
    end
    chk($sformatf("%s reg_1_sel", tag), obs_r1s, int'(instr[9:7]));
    chk($sformatf("%s reg_2_sel", tag), obs_r2s, int'(instr[6:4]));
    chk($sformatf("%s r1_sel", tag), obs_r1sel, 0);
    chk($sformatf("%s bus invariants", tag), obs_viol, 0);
    chk($sformatf("%s pwrite", tag), obs_pwrite, (op == 6) ? 1 : 0);
    chk($sformatf("%s next state", tag), obs_end, 0);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0]   ri;
    logic [DW-1:0] ra, rb;
    int            cnt;

    tbl[0] = '{16'h0CA0, 32'd1, 32'd2, 0, 0, 5, 0, 1, 1'b0, '0};
    tbl[1] = '{16'h28FF, 32'd1, 32'd2, 0, 0, 5, 0, 1, 1'b1, 32'hFFFF_FFFF};
    tbl[2] = '{16'h80A3, 32'd5, 32'd5, 0, 0, 4, 0, 0, 1'b1, 32'd3};
    tbl[3] = '{16'h80A3, 32'd5, 32'd6, 0, 0, 4, 1, 0, 1'b1, 32'd3};
    tbl[4] = '{16'hA0C2, 32'd8, 32'd9, 0, 3, 10, 0, 1, 1'b1, 32'd2};
    tbl[5] = '{16'hC0C2, 32'd8, 32'd9, 0, 0, 6, 0, 0, 1'b1, 32'd2};
    tbl[6] = '{16'hE090, 32'd4, 32'd4, 0, 0, 4, 2, 0, 1'b1, 32'd16};
    tbl[7] = '{16'h4CA0, 32'd3, 32'd1, 2, 0, 7, 0, 1, 1'b0, '0};
    tbl[8] = '{16'h6CA0, 32'd3, 32'd1, 1, 0, 6, 0, 1, 1'b0, '0};

    #3;
    chk("reset state", state, 0);
    chk("reset psel", psel, 0);
    chk("reset penable", penable, 0);
    chk("reset fault", fault, 0);
    chk("reset strobes", {pwrite, ir_load, pc_load, rf_we}, 0);
    release_reset();
    #1;
    chk("post-reset psel", psel, 1);
    chk("post-reset addr_sel", addr_sel, 0);

    for (int i = 0; i < 9; i++) begin
      check_instr($sformatf("vec%0d", i), tbl[i].ir, tbl[i].a, tbl[i].b, tbl[i].fw, tbl[i].mw);
      chk($sformatf("vec%0d table latency", i), obs_lat, tbl[i].lat);
      chk($sformatf("vec%0d table pc_sel", i), obs_pcsel, tbl[i].pcsel);
      chk($sformatf("vec%0d table rf_we", i), obs_rfwe, tbl[i].rfwe);
      if (tbl[i].has_imm) chk($sformatf("vec%0d table imm", i), obs_imm, tbl[i].imm);
    end

    // Bus error on a store: absorbing fault, no PC update, async reset recovers
    run_instr(16'hC0C2, 32'd1, 32'd2, 0, 1, 1'b1);
    chk("sw err fault seen", obs_fault, 1);
    chk("sw err pc_load", obs_pcl, 0);
    chk("sw err state", obs_end, 7);
    repeat (2) @(posedge clk);
    #2;
    chk("fault sticky", fault, 1);
    chk("fault psel", psel, 0);
    reset = 1'b0;
    #1;
    chk("fault reset state", state, 0);
    chk("fault reset flag", fault, 0);
    release_reset();

    // Reset in the middle of a fetch drops the handshake immediately
    pready = 1'b0;
    @(posedge clk); #2;
    chk("mid fetch penable", penable, 1);
    reset = 1'b0;
    #1;
    chk("mid reset psel", psel, 0);
    chk("mid reset penable", penable, 0);
    chk("mid reset state", state, 0);
    release_reset();

    for (int n = 0; n < 40; n++) begin
      ri = 16'($urandom);
      ra = DW'($urandom_range(0, 15));
      rb = ($urandom_range(0, 1) == 1) ? ra : DW'($urandom_range(0, 15));
      check_instr($sformatf("rnd%0d op%0d", n, ri[15:13]), ri, ra, rb,
                  $urandom_range(0, 3), $urandom_range(0, 3));
    end

`ifdef CPU_CTRL_TIMEOUT_EN
    pready = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20 && state != 3'd7; c++) begin
      if (state == 3'd1) cnt++;
      @(posedge clk); #1;
    end
    chk("timeout wait cycles", cnt, 4);
    chk("timeout state", state, 7);
    reset = 1'b0;
    release_reset();
    check_instr("ready on 4th wait", 16'h0CA0, 32'd1, 32'd2, 3, 0);
`else
    cnt = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
